rx_memory_control: RTL and testbench

RX_MEMORY_CONTROL -- requirements
Module: rx_memory_control

---
 rtl/rx_memory_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_rx_memory_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_memory_control.sv
// Ethernet RX payload to VRAM writer with per-segment duplicate/commit tracking.
// Optional RX_STATS_EN adds saturating CRC-error and duplicate-skip counters.
module rx_memory_control #(
   parameter int SEGMENT_NUMBER_MAX = 150,
   parameter int PIXELS_PER_SEGMENT = 479,
   parameter int MAX_VRAMADDR       = 57600
) (
   input  logic        clk125MHz,
   input  logic        rst,
   input  logic        rx_sof,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_eof,
   input  logic        rx_crc_ok,
   input  logic [7:0]  txid,
   input  logic [7:0]  redundancy,
   input  logic [15:0] segment_num,
   input  logic [15:0] segment_num_max,
   output logic        vram_we,
   output logic [23:0] vram_addr,
   output logic [23:0] vram_din,
   output logic        frame_done,
   output logic [15:0] seg_count,
   output logic [15:0] crc_err_count,
   output logic [15:0] dup_skip_count
);

   localparam int          SW      = $clog2(SEGMENT_NUMBER_MAX);
   localparam logic [23:0] PPS     = 24'(PIXELS_PER_SEGMENT);
   localparam logic [15:0] PIX_MAX = 16'(PIXELS_PER_SEGMENT);
   localparam logic [23:0] MAXA    = 24'(MAX_VRAMADDR);
   localparam logic [15:0] SEG_LIM = 16'(SEGMENT_NUMBER_MAX);

   typedef enum logic [2:0] {IDLE, CHECK, PAYLOAD, SKIP, COMMIT} state_t;

   state_t                        state_q, state_d;
   logic [15:0]                   seg_q, seg_d, segmax_q, segmax_d;
   logic [7:0]                    txid_q, txid_d, red_q, red_d;
   logic [7:0]                    hold_q, hold_d, r_q, r_d, g_q, g_d;
   logic                          crc_q, crc_d;
   logic [23:0]                   base_q, base_d;
   logic [1:0]                    phase_q, phase_d;
   logic [15:0]                   pix_q, pix_d, cnt_q, cnt_d;
   logic [SEGMENT_NUMBER_MAX-1:0] bitmap_q, bitmap_d;
   logic                          we_q, we_d, done_q, done_d;
   logic [23:0]                   addr_q, addr_d, din_q, din_d;

   logic [SW-1:0] idx;
   logic [23:0]   pix_addr;
   logic [15:0]   cnt_inc;
   logic          seg_ok, newfrm, dup, pass, v, e, take;
   logic          crc_inc, dup_inc;

   assign idx      = seg_q[SW-1:0];
   assign pix_addr = base_q + 24'(pix_q);
   assign cnt_inc  = cnt_q + 16'd1;
   assign seg_ok   = seg_q < SEG_LIM;
   assign newfrm   = txid_q == 8'd1 && seg_q == 16'd0 && cnt_q != 16'd0;
   assign dup      = seg_ok && bitmap_q[idx] && !newfrm;
   assign pass     = seg_ok && seg_q < segmax_q && txid_q != 8'd0 &&
                     txid_q <= red_q && !dup;
   // a new rx_sof byte always belongs to the next packet
   assign v        = rx_valid && !rx_sof;
   assign e        = rx_eof && !rx_sof;
   assign take     = v && pix_q < PIX_MAX;

   always_comb begin
      state_d  = state_q;
      seg_d    = seg_q;
      segmax_d = segmax_q;
      txid_d   = txid_q;
      red_d    = red_q;
      hold_d   = hold_q;
      r_d      = r_q;
      g_d      = g_q;
      crc_d    = crc_q;
      base_d   = base_q;
      phase_d  = phase_q;
      pix_d    = pix_q;
      cnt_d    = cnt_q;
      bitmap_d = bitmap_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      crc_inc  = 1'b0;
      dup_inc  = 1'b0;
      case (state_q)
         CHECK: begin
            if (newfrm) begin
               bitmap_d = '0;
               cnt_d    = '0;
            end
            dup_inc = dup;
            // held sof byte becomes R; a byte landing here becomes G
            r_d     = hold_q;
            phase_d = 2'd1;
            pix_d   = '0;
            base_d  = 24'(seg_q) * PPS;
            if (v) begin
               g_d     = rx_data;
               phase_d = 2'd2;
            end
            if (e) begin
               crc_d   = rx_crc_ok;
               crc_inc = pass && !rx_crc_ok;
               state_d = pass ? COMMIT : IDLE;
            end else begin
               state_d = pass ? PAYLOAD : SKIP;
            end
         end
         PAYLOAD: begin
            if (take) begin
               case (phase_q)
                  2'd0: begin
                     r_d     = rx_data;
                     phase_d = 2'd1;
                  end
                  2'd1: begin
                     g_d     = rx_data;
                     phase_d = 2'd2;
                  end
                  default: begin
                     phase_d = 2'd0;
                     pix_d   = pix_q + 16'd1;
                     if (pix_addr < MAXA) begin
                        we_d   = 1'b1;
                        addr_d = pix_addr;
                        din_d  = {r_q, g_q, rx_data};
                     end
                  end
               endcase
            end
            if (e) begin
               crc_d   = rx_crc_ok;
               crc_inc = !rx_crc_ok;
               state_d = COMMIT;
            end
         end
         SKIP: begin
            if (e) state_d = IDLE;
         end
         COMMIT: begin
            state_d = IDLE;
            if (crc_q) begin
               if (cnt_inc >= segmax_q) begin
                  done_d   = 1'b1;
                  bitmap_d = '0;
                  cnt_d    = '0;
               end else begin
                  bitmap_d[idx] = 1'b1;
                  cnt_d         = cnt_inc;
               end
            end
         end
         default: ;
      endcase
      if (rx_sof) begin
         state_d  = CHECK;
         seg_d    = segment_num;
         segmax_d = segment_num_max;
         txid_d   = txid;
         red_d    = redundancy;
         hold_d   = rx_data;
      end
   end

   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         state_q  <= IDLE;
         seg_q    <= '0;
         segmax_q <= '0;
         txid_q   <= '0;
         red_q    <= '0;
         hold_q   <= '0;
         r_q      <= '0;
         g_q      <= '0;
         crc_q    <= 1'b0;
         base_q   <= '0;
         phase_q  <= '0;
         pix_q    <= '0;
         cnt_q    <= '0;
         bitmap_q <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
      end else begin
         state_q  <= state_d;
         seg_q    <= seg_d;
         segmax_q <= segmax_d;
         txid_q   <= txid_d;
         red_q    <= red_d;
         hold_q   <= hold_d;
         r_q      <= r_d;
         g_q      <= g_d;
         crc_q    <= crc_d;
         base_q   <= base_d;
         phase_q  <= phase_d;
         pix_q    <= pix_d;
         cnt_q    <= cnt_d;
         bitmap_q <= bitmap_d;
         we_q     <= we_d;
         done_q   <= done_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
      end
   end

   // a write registered just before reset must not land on the reset cycle
   assign vram_we    = we_q & ~rst;
   assign vram_addr  = addr_q;
   assign vram_din   = din_q;
   assign frame_done = done_q;
   assign seg_count  = cnt_q;

`ifdef RX_STATS_EN
   logic [15:0] crc_err_q, crc_err_d, dup_skip_q, dup_skip_d;

   assign crc_err_d  = (crc_inc && crc_err_q != 16'hFFFF) ?
                       crc_err_q + 16'd1 : crc_err_q;
   assign dup_skip_d = (dup_inc && dup_skip_q != 16'hFFFF) ?
                       dup_skip_q + 16'd1 : dup_skip_q;

   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         crc_err_q  <= '0;
         dup_skip_q <= '0;
      end else begin
         crc_err_q  <= crc_err_d;
         dup_skip_q <= dup_skip_d;
      end
   end

   assign crc_err_count  = crc_err_q;
   assign dup_skip_count = dup_skip_q;
`else
   logic unused_stats;
   assign unused_stats   = crc_inc | dup_inc;
   assign crc_err_count  = '0;
   assign dup_skip_count = '0;
`endif

endmodule

// File: tb/tb_rx_memory_control.sv
// Randomized bench for rx_memory_control against a packet-level model.
// Builds with or without RX_STATS_EN.
module tb_rx_memory_control;

   localparam int SMAX = 150;
   localparam int PPS  = 479;
   localparam int VMAX = 57600;
`ifdef RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk125MHz = 1'b0;
   logic        rst = 1'b1;
   logic        rx_sof = 1'b0, rx_valid = 1'b0, rx_eof = 1'b0, rx_crc_ok = 1'b0;
   logic [7:0]  rx_data = '0, txid = '0, redundancy = '0;
   logic [15:0] segment_num = '0, segment_num_max = '0;
   logic        vram_we, frame_done;
   logic [23:0] vram_addr, vram_din;
   logic [15:0] seg_count, crc_err_count, dup_skip_count;

   rx_memory_control dut (
      .clk125MHz(clk125MHz), .rst(rst),
      .rx_sof(rx_sof), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_eof(rx_eof), .rx_crc_ok(rx_crc_ok),
      .txid(txid), .redundancy(redundancy),
      .segment_num(segment_num), .segment_num_max(segment_num_max),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
      .frame_done(frame_done), .seg_count(seg_count),
      .crc_err_count(crc_err_count), .dup_skip_count(dup_skip_count)
   );

   always #4 clk125MHz = ~clk125MHz;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model state
   bit          bm[SMAX];
   int          m_cnt, m_fd, m_crc, m_dup;
   logic [47:0] exp_q[$];
   logic [47:0] got_q[$];
   logic [7:0]  pkt[$];
   int          fd_seen;

   always @(negedge clk125MHz) begin
      if (vram_we) got_q.push_back({vram_addr, vram_din});
      if (frame_done) fd_seen++;
   end

   function automatic void model_reset();
      foreach (bm[i]) bm[i] = 1'b0;
      m_cnt = 0;
      m_fd  = 0;
      m_crc = 0;
      m_dup = 0;
   endfunction

   function automatic void model_pkt(input int seg, input int tx, input int red,
                                     input int smx, input bit crc, input bit eof,
                                     input int rst_at);
      bit dup, pass;
      int npix, a;
      if (tx == 1 && seg == 0 && m_cnt != 0) begin
         foreach (bm[i]) bm[i] = 1'b0;
         m_cnt = 0;
      end
      dup  = (seg < SMAX) ? bm[seg] : 1'b0;
      pass = seg < SMAX && seg < smx && tx != 0 && tx <= red && !dup;
      if (dup) m_dup++;
      if (!pass) return;
      npix = pkt.size() / 3;
      if (npix > PPS) npix = PPS;
      for (int p = 0; p < npix; p++) begin
         if (rst_at >= 0 && 3 * p + 3 >= rst_at) break;
         a = seg * PPS + p;
         if (a < VMAX)
            exp_q.push_back({24'(a), pkt[3*p], pkt[3*p+1], pkt[3*p+2]});
      end
      if (eof && rst_at < 0) begin
         if (!crc) begin
            m_crc++;
         end else begin
            m_cnt++;
            if (m_cnt == smx) begin
               m_fd++;
               m_cnt = 0;
               foreach (bm[i]) bm[i] = 1'b0;
            end else begin
               bm[seg] = 1'b1;
            end
         end
      end
   endfunction

   task automatic fill(input int n, input bit pattern);
      pkt.delete();
      for (int i = 0; i < n; i++)
         pkt.push_back(pattern ? 8'(i % 3 + 1) : 8'($urandom));
   endtask

   task automatic compare(input string tag);
      bit bad;
      int n;
      chk({tag, ".nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         bad = got_q[i] !== exp_q[i];
         chk({tag, ".wr"}, got_q[i], exp_q[i]);
         if (bad) break;
      end
      chk({tag, ".segcnt"}, seg_count, m_cnt);
      chk({tag, ".fdone"}, fd_seen, m_fd);
      chk({tag, ".crcerr"}, crc_err_count, STATS ? m_crc : 0);
      chk({tag, ".dupskip"}, dup_skip_count, STATS ? m_dup : 0);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic run(input string tag, input int seg, input int tx, input int red,
                      input int smx, input bit crc, input bit eof, input bit gaps,
                      input int rst_at);
      model_pkt(seg, tx, red, smx, crc, eof, rst_at);
      segment_num     = 16'(seg);
      txid            = 8'(tx);
      redundancy      = 8'(red);
      segment_num_max = 16'(smx);
      for (int i = 0; i < pkt.size(); i++) begin
         if (gaps && i > 0 && $urandom_range(3) == 0) begin
            rx_sof   = 1'b0;
            rx_valid = 1'b0;
            @(posedge clk125MHz) #1;
         end
         rx_sof   = (i == 0);
         rx_valid = 1'b1;
         rx_data  = pkt[i];
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk125MHz);
            chk({tag, ".we_in_rst"}, vram_we, 0);
            @(posedge clk125MHz) #1;
            rst      = 1'b0;
            rx_valid = 1'b0;
            break;
         end
         @(posedge clk125MHz) #1;
      end
      rx_sof   = 1'b0;
      rx_valid = 1'b0;
      if (rst_at >= 0) begin
         model_reset();
      end else if (eof) begin
         rx_eof    = 1'b1;
         rx_crc_ok = crc;
         @(posedge clk125MHz) #1;
         rx_eof    = 1'b0;
         rx_crc_ok = 1'b0;
      end
      if (eof || rst_at >= 0) begin
         repeat (3) @(posedge clk125MHz) #1;
         compare(tag);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk125MHz) #1;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk125MHz) #1;
      got_q.delete();
      exp_q.delete();
      fd_seen = 0;
   endtask

   initial begin
      fd_seen = 0;
      model_reset();
      repeat (3) @(posedge clk125MHz) #1;
      rst = 1'b0;
      @(negedge clk125MHz);
      chk("rst.we", vram_we, 0);
      chk("rst.addr", vram_addr, 0);
      chk("rst.din", vram_din, 0);
      chk("rst.fdone", frame_done, 0);
      chk("rst.segcnt", seg_count, 0);
      chk("rst.crcerr", crc_err_count, 0);
      chk("rst.dupskip", dup_skip_count, 0);
      @(posedge clk125MHz) #1;

      fill(1437, 1'b1);
      run("seg0", 0, 1, 1, SMAX, 1'b1, 1'b1, 1'b1, -1);

      fill(1437, 1'b0);
      run("seg5.tx1bad", 5, 1, 3, SMAX, 1'b0, 1'b1, 1'b1, -1);
      fill(1437, 1'b0);
      run("seg5.tx2", 5, 2, 3, SMAX, 1'b1, 1'b1, 1'b1, -1);
      fill(1437, 1'b0);
      run("seg5.tx3dup", 5, 3, 3, SMAX, 1'b1, 1'b1, 1'b1, -1);

      fill(60, 1'b0);
      run("seg200", 200, 1, 1, SMAX, 1'b1, 1'b1, 1'b0, -1);
      fill(60, 1'b0);
      run("txid0", 7, 0, 1, SMAX, 1'b1, 1'b1, 1'b0, -1);
      fill(62, 1'b0);
      run("seg7", 7, 1, 1, SMAX, 1'b1, 1'b1, 1'b1, -1);

      fill(92, 1'b0);
      run("seg3.cut", 3, 1, 1, SMAX, 1'b1, 1'b0, 1'b1, -1);
      fill(300, 1'b0);
      run("seg4", 4, 1, 1, SMAX, 1'b1, 1'b1, 1'b1, -1);

      for (int k = 0; k < 14; k++) begin
         fill($urandom_range(1, 1500), 1'b0);
         run("rand", $urandom_range(0, 24), $urandom_range(0, 4),
             $urandom_range(1, 3), SMAX, $urandom_range(0, 3) != 0,
             1'b1, 1'b1, -1);
      end

      fill(1437, 1'b0);
      run("rstmid", 9, 1, 1, SMAX, 1'b1, 1'b0, 1'b0, 600);
      fill(1437, 1'b0);
      run("after_rst", 0, 1, 1, SMAX, 1'b1, 1'b1, 1'b1, -1);

      do_reset();
      for (int s = 0; s < 120; s++) begin
         fill(6, 1'b0);
         run("frame", s, 1, 1, 121, 1'b1, 1'b1, 1'b0, -1);
      end
      fill(1437, 1'b0);
      run("frame.seg120", 120, 1, 1, 121, 1'b1, 1'b1, 1'b1, -1);
      chk("frame.fdone_once", fd_seen, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
